// File: rtl/stack_rpn_engine.sv
// RPN command engine over an external pushdown stack; MUL (op 111) exists only with RPN_MUL_EN.
// Latency: 2 + stack accesses cycles per command (illegal commands: 2 cycles), no overlap.
// Backpressure: CmdReady is high only in IDLE; the upstream holds its command until it is accepted.
module stack_rpn_engine (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [2:0] CmdOp,
    input  logic [7:0] CmdData,
    output logic       ResValid,
    output logic [7:0] Result,
    output logic       Error,
    output logic [7:0] StkI,
    input  logic [7:0] StkO,
    output logic       StkPushPop,
    output logic       StkEnable,
    input  logic       StkEmpty,
    input  logic       StkFull,
    output logic [9:0] Depth
);
    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [2:0] {IDLE, POPA, POPB, PUSH1, PUSH2, DONE} state_t;

    state_t     r_state;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_stki;
    logic [7:0] r_result;
    logic [9:0] r_depth;
    logic       r_res_vld;
    logic       r_err;
    logic       r_stk_en;
    logic       r_stk_pp;
    logic       w_illegal;
    logic       w_bin_illegal;
    logic       w_op_bin;
    logic [7:0] w_stk_i;

    function automatic logic [7:0] f_alu(input logic [2:0] op, input logic [7:0] b, input logic [7:0] a);
        case (op)
            OP_ADD:  f_alu = b + a;
            OP_SUB:  f_alu = b - a;
            OP_AND:  f_alu = b & a;
            OP_XOR:  f_alu = b ^ a;
`ifdef RPN_MUL_EN
            OP_MUL:  f_alu = b * a;
`endif
            default: f_alu = 8'h00;
        endcase
    endfunction

    // Binary ops pop two and push one, so both stack flags disqualify them.
    assign w_bin_illegal = (r_depth < 10'd2) || StkEmpty || StkFull;

    always_comb begin
        w_illegal = 1'b0;
        case (CmdOp)
            OP_PUSH: w_illegal = (r_depth == 10'd1023) || StkFull;
            OP_POP:  w_illegal = (r_depth == 10'd0) || StkEmpty;
            OP_DUP:  w_illegal = (r_depth == 10'd0) || (r_depth >= 10'd1022) || StkEmpty || StkFull;
`ifdef RPN_MUL_EN
            OP_MUL:  w_illegal = w_bin_illegal;
`else
            OP_MUL:  w_illegal = 1'b1;
`endif
            default: w_illegal = w_bin_illegal;
        endcase
    end

    // Binary results come straight from the captured operands during PUSH1.
    assign w_op_bin = (r_op != OP_PUSH) && (r_op != OP_POP) && (r_op != OP_DUP);
    assign w_stk_i  = w_op_bin ? f_alu(r_op, r_b, r_a) : r_stki;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_op      <= OP_PUSH;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_stki    <= 8'h00;
            r_result  <= 8'h00;
            r_depth   <= 10'd0;
            r_res_vld <= 1'b0;
            r_err     <= 1'b0;
            r_stk_en  <= 1'b0;
            r_stk_pp  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (CmdValid) begin
                        r_op   <= CmdOp;
                        r_stki <= CmdData;
                        if (w_illegal) begin
                            r_state <= DONE;
                            r_err   <= 1'b1;
                        end else if (CmdOp == OP_PUSH) begin
                            r_state  <= PUSH1;
                            r_stk_en <= 1'b1;
                            r_stk_pp <= 1'b0;
                        end else begin
                            r_state  <= POPA;
                            r_stk_en <= 1'b1;
                            r_stk_pp <= 1'b1;
                        end
                    end
                end
                POPA: begin
                    r_a     <= StkO;
                    r_depth <= r_depth - 10'd1;
                    case (r_op)
                        OP_POP: begin
                            r_state   <= DONE;
                            r_stk_en  <= 1'b0;
                            r_stk_pp  <= 1'b0;
                            r_res_vld <= 1'b1;
                            r_result  <= StkO;
                        end
                        OP_DUP: begin
                            r_state  <= PUSH1;
                            r_stk_pp <= 1'b0;
                            r_stki   <= StkO;
                        end
                        default: r_state <= POPB;
                    endcase
                end
                POPB: begin
                    r_b      <= StkO;
                    r_depth  <= r_depth - 10'd1;
                    r_state  <= PUSH1;
                    r_stk_pp <= 1'b0;
                end
                PUSH1: begin
                    r_depth <= r_depth + 10'd1;
                    if (r_op == OP_DUP) begin
                        r_state <= PUSH2;
                    end else begin
                        r_state   <= DONE;
                        r_stk_en  <= 1'b0;
                        r_res_vld <= 1'b1;
                        r_result  <= w_stk_i;
                    end
                end
                PUSH2: begin
                    r_depth   <= r_depth + 10'd1;
                    r_state   <= DONE;
                    r_stk_en  <= 1'b0;
                    r_res_vld <= 1'b1;
                    r_result  <= w_stk_i;
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_res_vld <= 1'b0;
                    r_err     <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign CmdReady   = (r_state == IDLE);
    assign ResValid   = r_res_vld;
    assign Result     = r_result;
    assign Error      = r_err;
    assign StkI       = w_stk_i;
    assign StkPushPop = r_stk_pp;
    assign StkEnable  = r_stk_en;
    assign Depth      = r_depth;
endmodule

// File: doc/stack_rpn_engine.md
STACK_RPN_ENGINE -- requirements
Module: stack_rpn_engine

Interface
REQ-001 SHALL have ports, clock and reset first: CLK in 1 clock; Reset in 1 asynchronous active-low reset.
REQ-002 SHALL have CmdValid in 1, CmdReady out 1, CmdOp in 3, CmdData in 8: command handshake.
REQ-003 SHALL have ResValid out 1, Result out 8, Error out 1: result/status.
REQ-004 SHALL have StkI out 8 (push data), StkO in 8 (pop data), StkPushPop out 1 (1=pop, 0=push), StkEnable out 1, StkEmpty in 1, StkFull in 1: pushdown-stack port.
REQ-005 SHALL have Depth out 10: tracked stack occupancy.

Function
REQ-006 SHALL decode CmdOp: 000 PUSH CmdData; 001 POP; 010 ADD; 011 SUB; 100 AND; 101 XOR; 110 DUP; 111 MUL (see Configuration).
REQ-007 SHALL use FSM states IDLE, POPA, POPB, PUSH1, PUSH2, DONE; CmdReady=1 only in IDLE.
REQ-008 SHALL accept a command on CLK edge with CmdValid&CmdReady, latching op and CmdData.
REQ-009 SHALL assert StkEnable for exactly one cycle per stack access; StkEnable=0 in IDLE and DONE.
REQ-010 SHALL in POPA/POPB drive StkPushPop=1 and sample StkO at the end of that cycle into A/B.
REQ-011 SHALL in PUSH1/PUSH2 drive StkPushPop=0 and StkI with the push value.
REQ-012 SHALL sequence: PUSH IDLE->PUSH1->DONE; POP IDLE->POPA->DONE; binary ops IDLE->POPA->POPB->PUSH1->DONE; DUP IDLE->POPA->PUSH1->PUSH2->DONE; DONE->IDLE.
REQ-013 SHALL compute binary results mod 256: A = first popped (top), B = second; ADD B+A, SUB B-A, AND B&A, XOR B^A, MUL low 8 bits of B*A.
REQ-014 SHALL in DONE pulse ResValid=1 one cycle with Result = pushed value (PUSH, binary, DUP) or A (POP).
REQ-015 SHALL hold Result between pulses; ResValid=0 outside DONE.
REQ-016 SHALL maintain Depth: +1 per push strobe, -1 per pop strobe, range 0..1023.
REQ-017 SHALL check legality at acceptance from Depth: PUSH illegal at 1023; POP illegal at 0; binary illegal below 2; DUP illegal at 0 or 1022..1023.
REQ-018 SHALL treat StkFull=1 as illegal for push-producing ops and StkEmpty=1 as illegal for pop ops, regardless of Depth.
REQ-019 SHALL on illegal command go IDLE->DONE directly, issue no stack access, pulse Error=1 with ResValid=0 in DONE, Result unchanged.
REQ-020 SHALL ignore CmdValid outside IDLE; upstream holds command until CmdReady.
REQ-021 SHALL give throughput of one command per (2 + stack accesses) cycles, no overlap.

Reset
REQ-022 SHALL on Reset=0 asynchronously force state IDLE, Depth=0, Result=0, A=B=0, ResValid=0, Error=0, StkEnable=0, StkPushPop=0, StkI=0.
REQ-023 SHALL abandon any in-flight command on reset mid-operation; the stack is reset in the same reset domain.
REQ-024 SHALL leave reset with CmdReady=1 in the first cycle after Reset deasserts.

Configuration
REQ-025 SHALL with RPN_MUL_EN defined implement MUL for CmdOp 111 (legality as binary ops).
REQ-026 SHALL with RPN_MUL_EN undefined treat CmdOp 111 as illegal: Error pulse, no stack access, no multiplier logic.

Verification
REQ-027 PUSH 0x05, PUSH 0x03, SUB -> pop strobes read 0x03 then 0x05, push 0x02, ResValid with Result=0x02, Depth=1.
REQ-028 POP after reset (Depth 0) -> DONE after one cycle, Error=1, ResValid=0, StkEnable never asserted.
REQ-029 PUSH 0xF0, PUSH 0x20, ADD -> Result=0x10 (wrap), Depth=1; then DUP -> two pushes of 0x10, Depth=2.
REQ-030 1023 PUSH commands then PUSH 0xAA -> Error=1, no push; Depth stays 1023, StkFull=1.
REQ-031 Reset=0 asserted during POPB of ADD -> immediately IDLE, Depth=0, ResValid=0, CmdReady=1 after release.
REQ-032 PUSH 0x07, PUSH 0x06, CmdOp 111 -> Result=0x2A with RPN_MUL_EN; Error=1 and Depth=2 without it.
